dilithium_stream_adapter: RTL

- Parametrised output adapter between the Dilithium core's result stream and the external valid/ready bus.
- Buffers core output in a first-word-fall-through (FWFT) FIFO and applies backpressure to the core when the FIFO is full.
- Derives the expected transaction length from mode/sec_lvl or a runtime override, counts words on both sides, and asserts last on the final word.
- Flags length errors. Supports abort mid-transaction.

---
 rtl/dilithium_stream_adapter.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/dilithium_stream_adapter.sv
// dilithium_stream_adapter
// Output adapter between the Dilithium core result stream and an external
// valid/ready bus. Core words are buffered in a first-word-fall-through FIFO,
// the expected transaction length is derived from mode/sec_lvl (or an
// override), and last/done are generated from the output word count.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   start, abort          one-cycle control pulses (abort has priority)
//   mode, sec_lvl         select the expected length; mode 3 uses len_override
//   dilithium_valid_o/_ready_o/_data_o   core-side handshake (adapter input)
//   valid_o/ready_o/data_o               external-side handshake (adapter output)
//   last                  data_o is the final word of the transaction
//   busy                  transaction in progress
//   done                  one-cycle pulse after the final word leaves
//   err_len               sticky length/config error, cleared by start or abort
//   fill                  FIFO occupancy
module dilithium_stream_adapter #(
    parameter int W     = 64,
    parameter int DEPTH = 1024,
    parameter int LEN_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [1:0]             mode,
    input  logic [2:0]             sec_lvl,
    input  logic [LEN_W-1:0]       len_override,
    input  logic                   dilithium_valid_o,
    output logic                   dilithium_ready_o,
    input  logic [W-1:0]           dilithium_data_o,
    output logic                   valid_o,
    input  logic                   ready_o,
    output logic [W-1:0]           data_o,
    output logic                   last,
    output logic                   busy,
    output logic                   done,
    output logic                   err_len,
    output logic [$clog2(DEPTH):0] fill
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam logic [FW-1:0]    FILL_FULL = FW'(DEPTH);
    localparam logic [FW-1:0]    FILL_ZERO = {FW{1'b0}};
    localparam logic [FW-1:0]    FILL_ONE  = FW'(1'b1);
    localparam logic [AW-1:0]    PTR_LAST  = AW'(DEPTH - 1);
    localparam logic [AW-1:0]    PTR_ZERO  = {AW{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Expected word count for a transaction; zero marks an illegal configuration.
    function automatic logic [LEN_W-1:0] expected_len(input logic [1:0]       m,
                                                      input logic [2:0]       s,
                                                      input logic [LEN_W-1:0] ovr);
        logic [LEN_W-1:0] n;
        case (m)
            2'd0: begin
                case (s)
                    3'd2:    n = LEN_W'(10'd480);
                    3'd3:    n = LEN_W'(10'd744);
                    3'd5:    n = LEN_W'(10'd932);
                    default: n = LEN_ZERO;
                endcase
            end
            2'd1:    n = LEN_ONE;
            2'd2: begin
                case (s)
                    3'd2:    n = LEN_W'(10'd303);
                    3'd3:    n = LEN_W'(10'd412);
                    3'd5:    n = LEN_W'(10'd575);
                    default: n = LEN_ZERO;
                endcase
            end
            2'd3:    n = ovr;
            default: n = LEN_ZERO;
        endcase
        return n;
    endfunction

    // FIFO pointer increment with explicit wrap for non-power-of-two depths.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        logic [AW-1:0] q;
        if (p == PTR_LAST) begin
            q = PTR_ZERO;
        end else begin
            q = p + AW'(1'b1);
        end
        return q;
    endfunction

    state_t           state_r, state_nxt_s;
    logic [LEN_W-1:0] n_r, n_nxt_s;
    logic [LEN_W-1:0] in_cnt_r, in_cnt_nxt_s;
    logic [LEN_W-1:0] out_cnt_r, out_cnt_nxt_s;
    logic [AW-1:0]    wr_ptr_r, wr_ptr_nxt_s;
    logic [AW-1:0]    rd_ptr_r, rd_ptr_nxt_s;
    logic [FW-1:0]    fill_r, fill_nxt_s;
    logic             ready_r, ready_nxt_s;
    logic             valid_r, valid_nxt_s;
    logic             last_r, last_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             done_r, done_nxt_s;
    logic             err_r, err_nxt_s;
    logic [W-1:0]     mem_r [DEPTH];

    logic             wr_en_s;
    logic             rd_en_s;
    logic             final_out_s;
    logic [LEN_W-1:0] start_len_s;

    // Handshake decode and length lookup; ready_r is only ever set in FILL when not full.
    always_comb begin
        wr_en_s     = dilithium_valid_o && ready_r;
        rd_en_s     = valid_r && ready_o;
        final_out_s = rd_en_s && (out_cnt_r == (n_r - LEN_ONE));
        start_len_s = expected_len(mode, sec_lvl, len_override);
    end

    // Next-state logic for the FSM, counters, FIFO pointers and registered flags.
    always_comb begin
        state_nxt_s   = state_r;
        n_nxt_s       = n_r;
        in_cnt_nxt_s  = in_cnt_r;
        out_cnt_nxt_s = out_cnt_r;
        wr_ptr_nxt_s  = wr_ptr_r;
        rd_ptr_nxt_s  = rd_ptr_r;
        fill_nxt_s    = fill_r;
        err_nxt_s     = err_r;
        done_nxt_s    = 1'b0;

        if (abort) begin
            state_nxt_s   = ST_IDLE;
            in_cnt_nxt_s  = LEN_ZERO;
            out_cnt_nxt_s = LEN_ZERO;
            wr_ptr_nxt_s  = PTR_ZERO;
            rd_ptr_nxt_s  = PTR_ZERO;
            fill_nxt_s    = FILL_ZERO;
            err_nxt_s     = 1'b0;
        end else if (start && (state_r == ST_IDLE)) begin
            if (start_len_s == LEN_ZERO) begin
                err_nxt_s = 1'b1;
            end else begin
                state_nxt_s   = ST_FILL;
                n_nxt_s       = start_len_s;
                in_cnt_nxt_s  = LEN_ZERO;
                out_cnt_nxt_s = LEN_ZERO;
                wr_ptr_nxt_s  = PTR_ZERO;
                rd_ptr_nxt_s  = PTR_ZERO;
                fill_nxt_s    = FILL_ZERO;
                err_nxt_s     = 1'b0;
            end
        end else begin
            if (wr_en_s) begin
                wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
                in_cnt_nxt_s = in_cnt_r + LEN_ONE;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
                in_cnt_nxt_s = in_cnt_r;
            end

            if (rd_en_s) begin
                rd_ptr_nxt_s  = ptr_inc(rd_ptr_r);
                out_cnt_nxt_s = out_cnt_r + LEN_ONE;
            end else begin
                rd_ptr_nxt_s  = rd_ptr_r;
                out_cnt_nxt_s = out_cnt_r;
            end

            case ({wr_en_s, rd_en_s})
                2'b10:   fill_nxt_s = fill_r + FILL_ONE;
                2'b01:   fill_nxt_s = fill_r - FILL_ONE;
                default: fill_nxt_s = fill_r;
            endcase

            if (final_out_s) begin
                state_nxt_s = ST_IDLE;
                done_nxt_s  = 1'b1;
            end else if (wr_en_s && ((in_cnt_r + LEN_ONE) == n_r)) begin
                state_nxt_s = ST_DRAIN;
            end else begin
                state_nxt_s = state_r;
            end

            // Here start can only arrive while busy; a core word offered in DRAIN is an overrun.
            if (start || ((state_r == ST_DRAIN) && dilithium_valid_o && (out_cnt_r < n_r))) begin
                err_nxt_s = 1'b1;
            end else begin
                err_nxt_s = err_r;
            end
        end

        busy_nxt_s  = (state_nxt_s != ST_IDLE);
        ready_nxt_s = (state_nxt_s == ST_FILL) && (fill_nxt_s != FILL_FULL);
        valid_nxt_s = (state_nxt_s != ST_IDLE) && (fill_nxt_s != FILL_ZERO);
        // last follows the output count, not occupancy, so queued words behind it do not matter.
        last_nxt_s  = valid_nxt_s && (out_cnt_nxt_s == (n_nxt_s - LEN_ONE));
    end

    // State, counter, pointer and output flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            n_r       <= LEN_ZERO;
            in_cnt_r  <= LEN_ZERO;
            out_cnt_r <= LEN_ZERO;
            wr_ptr_r  <= PTR_ZERO;
            rd_ptr_r  <= PTR_ZERO;
            fill_r    <= FILL_ZERO;
            ready_r   <= 1'b0;
            valid_r   <= 1'b0;
            last_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            n_r       <= n_nxt_s;
            in_cnt_r  <= in_cnt_nxt_s;
            out_cnt_r <= out_cnt_nxt_s;
            wr_ptr_r  <= wr_ptr_nxt_s;
            rd_ptr_r  <= rd_ptr_nxt_s;
            fill_r    <= fill_nxt_s;
            ready_r   <= ready_nxt_s;
            valid_r   <= valid_nxt_s;
            last_r    <= last_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            err_r     <= err_nxt_s;
        end
    end

    // FIFO storage, written only on an accepted core word.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= dilithium_data_o;
        end
    end

    assign dilithium_ready_o = ready_r;
    assign valid_o           = valid_r;
    assign data_o            = mem_r[rd_ptr_r];
    assign last              = last_r;
    assign busy              = busy_r;
    assign done              = done_r;
    assign err_len           = err_r;
    assign fill              = fill_r;

endmodule
